ethernet_reply_arbiter: RTL and testbench
=========================================

Name: ethernet_reply_arbiter

Overview:
- Arbitrates the ARP, ICMP and UDP reply transmitters onto a single 8-bit reply byte stream toward the MAC.
- Replaces OR-of-valids muxing with request/grant sequencing.
- Guarantees one whole frame at a time, an enforced inter-frame gap, and fault detection (start timeout, underrun, oversize).

Parameters:
- NUM_REQ, 3, number of requesters; index 0=ARP, 1=ICMP, 2=UDP; lower index wins under fixed priority.
- IFG_BYTES, 12, idle cycles forced after every frame end or abort.
- START_TIMEOUT, 16, cycles a granted requester has to assert its first valid byte.
- MAX_FRAME_BYTES, 1518, byte limit; the byte that reaches it is forced as last.

Ports:
- i_clk  in  1  byte clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-requester frame request; level, held until granted.
- i_word  in  NUM_REQ*8  requester k byte at bits [8k+7:8k].
- i_valid  in  NUM_REQ  per-requester byte valid.
- i_last  in  NUM_REQ  per-requester last byte, qualified by i_valid.
- o_grant  out  NUM_REQ  one-hot grant; all zero when idle.
- o_word  out  8  forwarded byte.
- o_valid  out  1  forwarded byte valid.
- o_last  out  1  forwarded last byte.
- o_busy  out  1  high in WAIT, PASS and GAP.
- o_err  out  3  one-cycle pulses: [0] start timeout, [1] underrun, [2] oversize.

Behaviour:
- Reset: asynchronous on i_reset_n low; all outputs 0, state IDLE, counters 0, round-robin pointer 0. Reset mid-frame drops the frame immediately; no o_last is produced.
- IDLE:
  - Any i_req set: winner latched to g, o_grant[g]=1 on the next cycle, go to WAIT.
  - Requests seen during GAP are served on the first IDLE cycle.
- WAIT:
  - Timeout counter increments each cycle.
  - i_valid[g]=1: go to PASS; that byte is forwarded.
  - i_req[g] drops before the first valid: clear grant, return to IDLE with no gap and no error.
  - Counter reaches START_TIMEOUT: pulse o_err[0], clear grant, go to GAP.
- PASS:
  - Forwarding is registered, so latency is 1 cycle: o_word/o_valid/o_last <= i_word[g]/i_valid[g]/i_last[g].
  - Byte counter is 16-bit and saturating.
  - i_valid[g]&i_last[g]: frame ends; o_last=1 on that byte, grant cleared the following cycle, go to GAP.
  - i_valid[g] drops before last (underrun): o_valid=0, pulse o_err[1], clear grant, go to GAP. The downstream sees the frame without o_last.
  - Byte count reaches MAX_FRAME_BYTES without last: force o_last=1 on that byte, pulse o_err[2], clear grant, go to GAP.
- GAP: o_valid=0 for exactly IFG_BYTES cycles, then IDLE.
- Non-granted i_valid/i_word are ignored and never reach the output.
- o_last is never high without o_valid.
- o_grant never changes inside PASS.
- Simultaneous requests: resolved by the selector; only one grant per arbitration.

Optional Feature:
- Macro: ETH_REPLY_ARB_RR_EN.
- Defined: round-robin selection. The pointer advances to (g+1) mod NUM_REQ after each frame end, abort or timeout. The search starts at the pointer. A withdrawn request does not advance the pointer.
- Undefined: fixed priority ARP > ICMP > UDP; no pointer register.

Decomposition:
- Package eth_reply_arb_pkg:
  - State enum {IDLE, WAIT, PASS, GAP}.
  - Constants REQ_ARP=0, REQ_ICMP=1, REQ_UDP=2.
  - Error-bit indices ERR_TIMEOUT=0, ERR_UNDERRUN=1, ERR_OVERSIZE=2.
  - Default IFG/timeout/size values.
- Sub-module eth_reply_arb_select: combinational picker that takes i_req and the pointer and returns a one-hot winner and its index. Both selection modes live here.

Test Plan:
- ARP-only request, 60-byte frame: o_grant=001 one cycle after the request; 60 output bytes match input delayed 1 cycle; o_last on byte 60; 12 idle cycles follow; o_err=0.
- ARP, ICMP and UDP requests in the same cycle, 64-byte frames, fixed mode: service order 0,1,2 with a 12-cycle gap between frames. With ETH_REPLY_ARB_RR_EN defined: same first order; a re-asserted ARP request then waits behind pending ICMP/UDP.
- Granted UDP never asserts valid: o_err[0] pulses 16 cycles after the grant; grant clears; gap; the pending ICMP request is then granted.
- ICMP valid drops after byte 30 with no last: o_err[1] pulses, no o_last, grant clears, 12-cycle gap.
- UDP streams 1600 bytes with no last: o_last forced on byte 1518, o_err[2] pulses, subsequent UDP bytes not forwarded.
- i_reset_n low mid-PASS at byte 20: outputs 0 immediately; after release, a fresh ARP request is granted normally.

Source files
------------

// File: rtl/eth_reply_arb_pkg.sv
// Shared types and defaults for the Ethernet reply arbiter (ARP/ICMP/UDP onto one MAC byte stream).
// Optional round-robin selection is enabled by defining ETH_REPLY_ARB_RR_EN.
package eth_reply_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PASS = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam int unsigned REQ_ARP  = 0;
    localparam int unsigned REQ_ICMP = 1;
    localparam int unsigned REQ_UDP  = 2;

    localparam int unsigned ERR_TIMEOUT  = 0;
    localparam int unsigned ERR_UNDERRUN = 1;
    localparam int unsigned ERR_OVERSIZE = 2;
    localparam int unsigned ERR_W        = 3;

    localparam int unsigned DEF_NUM_REQ         = 3;
    localparam int unsigned DEF_IFG_BYTES       = 12;
    localparam int unsigned DEF_START_TIMEOUT   = 16;
    localparam int unsigned DEF_MAX_FRAME_BYTES = 1518;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BYTE_CNT_W = 16;

    // One forwarded beat toward the MAC.
    typedef struct packed {
        logic [BYTE_W-1:0] word;
        logic              valid;
        logic              last;
    } out_beat_t;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ethernet_reply_arbiter_if.sv
// Requester-side and MAC-side signals of the reply arbiter, grouped with master/slave views.
// The arbiter uses the slave modport; the requester/MAC environment uses master.
interface ethernet_reply_arbiter_if
    import eth_reply_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ*BYTE_W-1:0] i_word;
    logic [NUM_REQ-1:0]        i_valid;
    logic [NUM_REQ-1:0]        i_last;
    logic [NUM_REQ-1:0]        o_grant;
    logic [BYTE_W-1:0]         o_word;
    logic                      o_valid;
    logic                      o_last;
    logic                      o_busy;
    logic [ERR_W-1:0]          o_err;

    modport master (
        output i_req, i_word, i_valid, i_last,
        input  o_grant, o_word, o_valid, o_last, o_busy, o_err
    );

    modport slave (
        input  i_req, i_word, i_valid, i_last,
        output o_grant, o_word, o_valid, o_last, o_busy, o_err
    );
endinterface

// File: rtl/eth_reply_arb_select.sv
// Combinational winner picker: fixed priority (lowest index) by default,
// round-robin starting at ptr when ETH_REPLY_ARB_RR_EN is defined.
module eth_reply_arb_select
    import eth_reply_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W  = cnt_width(NUM_REQ - 1)
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef ETH_REPLY_ARB_RR_EN
    input  logic [IDX_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] onehot_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);
    logic        found;
    int unsigned pos;

    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        found    = 1'b0;
        pos      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef ETH_REPLY_ARB_RR_EN
            pos = 32'(ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
`else
            pos = i;
`endif
            if (!found && req[pos]) begin
                found         = 1'b1;
                onehot_c[pos] = 1'b1;
                idx_c         = IDX_W'(pos);
            end
        end
    end

    assign any_c = |req;

endmodule

// File: rtl/ethernet_reply_arbiter.sv
// Grants one reply transmitter at a time, forwards its frame with one cycle of latency,
// enforces an inter-frame gap and flags start timeout, underrun and oversize.
// Define ETH_REPLY_ARB_RR_EN for round-robin selection instead of fixed ARP>ICMP>UDP priority.
module ethernet_reply_arbiter
    import eth_reply_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = DEF_NUM_REQ,
    parameter int unsigned IFG_BYTES       = DEF_IFG_BYTES,
    parameter int unsigned START_TIMEOUT   = DEF_START_TIMEOUT,
    parameter int unsigned MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    ethernet_reply_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = cnt_width(NUM_REQ - 1);
    localparam int unsigned TMO_W = cnt_width(START_TIMEOUT);
    localparam int unsigned GAP_W = cnt_width(IFG_BYTES);

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [BYTE_CNT_W-1:0]   byte_q, byte_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    out_beat_t               out_q, out_d;
    logic                    busy_q, busy_d;
    logic [ERR_W-1:0]        err_q, err_d;

    logic                    g_req, g_valid, g_last;
    logic [BYTE_W-1:0]       g_word;
    logic [NUM_REQ-1:0]      sel_onehot;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_any;
    logic                    take_byte;
    logic                    end_frame;
    logic [BYTE_CNT_W-1:0]   byte_next;

`ifdef ETH_REPLY_ARB_RR_EN
    logic [IDX_W-1:0]        ptr_q, ptr_d;
`endif

    eth_reply_arb_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .req      (bus.i_req),
`ifdef ETH_REPLY_ARB_RR_EN
        .ptr      (ptr_q),
`endif
        .onehot_c (sel_onehot),
        .idx_c    (sel_idx),
        .any_c    (sel_any)
    );

    // Lane of the currently granted requester.
    always_comb begin
        g_req   = 1'b0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_word  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gidx_q == IDX_W'(k)) begin
                g_req   = bus.i_req[k];
                g_valid = bus.i_valid[k];
                g_last  = bus.i_last[k];
                g_word  = bus.i_word[BYTE_W*k +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        tmo_d     = tmo_q;
        byte_d    = byte_q;
        gap_d     = gap_q;
        out_d     = '0;
        err_d     = '0;
        take_byte = 1'b0;
        end_frame = 1'b0;
        byte_next = (byte_q == '1) ? byte_q : byte_q + BYTE_CNT_W'(1);
`ifdef ETH_REPLY_ARB_RR_EN
        ptr_d     = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    grant_d = sel_onehot;
                    gidx_d  = sel_idx;
                    tmo_d   = '0;
                    byte_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (g_valid) begin
                    take_byte = 1'b1;
                end else if (!g_req) begin
                    // Withdrawn before starting: no gap, no error, pointer untouched.
                    grant_d = '0;
                    state_d = IDLE;
                end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    end_frame          = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            PASS: begin
                if (g_valid) begin
                    take_byte = 1'b1;
                end else begin
                    err_d[ERR_UNDERRUN] = 1'b1;
                    end_frame           = 1'b1;
                end
            end
            GAP: begin
                // gap_q counts idle cycles after the cycle carrying o_last or the error pulse.
                if (gap_q == GAP_W'(IFG_BYTES)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_byte) begin
            byte_d      = byte_next;
            out_d.word  = g_word;
            out_d.valid = 1'b1;
            state_d     = PASS;
            if (g_last) begin
                out_d.last = 1'b1;
                end_frame  = 1'b1;
            end else if (byte_next >= BYTE_CNT_W'(MAX_FRAME_BYTES)) begin
                out_d.last          = 1'b1;
                err_d[ERR_OVERSIZE] = 1'b1;
                end_frame           = 1'b1;
            end
        end

        if (end_frame) begin
            grant_d = '0;
            gap_d   = '0;
            state_d = GAP;
`ifdef ETH_REPLY_ARB_RR_EN
            ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            tmo_q   <= '0;
            byte_q  <= '0;
            gap_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= '0;
`ifdef ETH_REPLY_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            tmo_q   <= tmo_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef ETH_REPLY_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.o_grant = grant_q;
    assign bus.o_word  = out_q.word;
    assign bus.o_valid = out_q.valid;
    assign bus.o_last  = out_q.last;
    assign bus.o_busy  = busy_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_ethernet_reply_arbiter.sv
// Directed bench for ethernet_reply_arbiter: frames, arbitration order, timeout, underrun,
// oversize and mid-frame reset. Expected order adapts when ETH_REPLY_ARB_RR_EN is defined.
module tb_ethernet_reply_arbiter;
    import eth_reply_arb_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    ethernet_reply_arbiter_if #(.NUM_REQ(N)) bus();

    ethernet_reply_arbiter #(
        .NUM_REQ         (N),
        .IFG_BYTES       (12),
        .START_TIMEOUT   (16),
        .MAX_FRAME_BYTES (1518)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] data(input int r, input int i);
        return 8'(i * 7 + r * 61);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req   = '0;
        bus.i_word  = '0;
        bus.i_valid = '0;
        bus.i_last  = '0;
    endtask

    task automatic drive_lane(input int r, input logic [7:0] w, input logic v, input logic l);
        bus.i_word[8*r +: 8] = w;
        bus.i_valid[r]       = v;
        bus.i_last[r]        = l;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Stream n bytes on lane r (other lanes carry noise); checks each forwarded byte.
    task automatic send_frame(input int r, input int n, input bit with_last, input string tag);
        int         bad = 0;
        logic [2:0] err_or = '0;
        logic [2:0] oh;
        oh = 3'(1 << r);
        for (int i = 1; i <= n; i++) begin
            for (int k = 0; k < N; k++)
                if (k != r) drive_lane(k, 8'hEE, 1'b1, 1'b1);
            drive_lane(r, data(r, i), 1'b1, 1'(with_last && i == n));
            bus.i_req[r] = 1'b0;
            step();
            if (bus.o_valid !== 1'b1 || bus.o_word !== data(r, i) ||
                bus.o_last !== 1'(with_last && i == n)) bad++;
            if (i < n && bus.o_grant !== oh) bad++;
            err_or |= bus.o_err;
        end
        for (int k = 0; k < N; k++) drive_lane(k, 8'h00, 1'b0, 1'b0);
        check_eq({tag, " data"}, 32'(bad), 32'd0);
        if (with_last) begin
            check_eq({tag, " grant_clr"}, 32'(bus.o_grant), 32'd0);
            check_eq({tag, " err"}, 32'(err_or), 32'd0);
        end
    endtask

    // Count busy cycles after the ending cycle; returns on the first IDLE cycle.
    task automatic wait_gap(input string tag);
        int   n = 0;
        logic v = 1'b0;
        while (n < 40) begin
            step();
            if (!bus.o_busy) break;
            n++;
            v |= bus.o_valid;
        end
        check_eq({tag, " gap_len"}, 32'(n), 32'd12);
        check_eq({tag, " gap_valid"}, 32'(v), 32'd0);
    endtask

    initial begin
        int order[3];
        int n;
        int bad;
        int fwd;

        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst grant", 32'(bus.o_grant), 32'd0);
        check_eq("rst valid", 32'(bus.o_valid), 32'd0);
        check_eq("rst last",  32'(bus.o_last),  32'd0);
        check_eq("rst busy",  32'(bus.o_busy),  32'd0);
        check_eq("rst err",   32'(bus.o_err),   32'd0);
        rst_n = 1'b1;
        step();

        // ARP-only 60-byte frame
        bus.i_req[REQ_ARP] = 1'b1;
        step();
        check_eq("t1 grant", 32'(bus.o_grant), 32'b001);
        check_eq("t1 busy",  32'(bus.o_busy),  32'd1);
        send_frame(REQ_ARP, 60, 1'b1, "t1");
        wait_gap("t1");

        // Request withdrawn before the first byte
        bus.i_req[REQ_ARP] = 1'b1;
        step();
        check_eq("wd grant", 32'(bus.o_grant), 32'b001);
        bus.i_req[REQ_ARP] = 1'b0;
        step();
        check_eq("wd grant_clr", 32'(bus.o_grant), 32'd0);
        check_eq("wd busy", 32'(bus.o_busy), 32'd0);
        check_eq("wd err",  32'(bus.o_err),  32'd0);

        // Simultaneous requests, 64-byte frames: order 0,1,2
        do_reset();
        bus.i_req = 3'b111;
        step();
        check_eq("t2 grant0", 32'(bus.o_grant), 32'b001);
        send_frame(REQ_ARP, 64, 1'b1, "t2 arp");
        wait_gap("t2 arp");
        step();
        check_eq("t2 grant1", 32'(bus.o_grant), 32'b010);
        send_frame(REQ_ICMP, 64, 1'b1, "t2 icmp");
        wait_gap("t2 icmp");
        step();
        check_eq("t2 grant2", 32'(bus.o_grant), 32'b100);
        send_frame(REQ_UDP, 64, 1'b1, "t2 udp");
        wait_gap("t2 udp");

        // ARP re-asserted while ICMP/UDP are pending
        bus.i_req = 3'b111;
        step();
        check_eq("t2b grant", 32'(bus.o_grant), 32'b001);
        send_frame(REQ_ARP, 4, 1'b1, "t2b first");
        bus.i_req[REQ_ARP] = 1'b1;
        wait_gap("t2b first");
`ifdef ETH_REPLY_ARB_RR_EN
        order = '{1, 2, 0};
`else
        order = '{0, 1, 2};
`endif
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("t2b grant%0d", k), 32'(bus.o_grant), 32'(1 << order[k]));
            send_frame(order[k], 4, 1'b1, $sformatf("t2b f%0d", k));
            wait_gap($sformatf("t2b f%0d", k));
        end

        // UDP granted but silent: start timeout, then pending ICMP is served
        bus.i_req[REQ_UDP] = 1'b1;
        step();
        check_eq("t3 grant", 32'(bus.o_grant), 32'b100);
        bus.i_req[REQ_ICMP] = 1'b1;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (bus.o_err != 3'b000) break;
        end
        check_eq("t3 tmo_cycles", 32'(n), 32'd16);
        check_eq("t3 err", 32'(bus.o_err), 32'b001);
        check_eq("t3 grant_clr", 32'(bus.o_grant), 32'd0);
        check_eq("t3 valid", 32'(bus.o_valid), 32'd0);
        bus.i_req[REQ_UDP] = 1'b0;
        wait_gap("t3");
        step();
        check_eq("t3 icmp grant", 32'(bus.o_grant), 32'b010);

        // ICMP underrun after byte 30
        send_frame(REQ_ICMP, 30, 1'b0, "t4");
        step();
        check_eq("t4 valid", 32'(bus.o_valid), 32'd0);
        check_eq("t4 last",  32'(bus.o_last),  32'd0);
        check_eq("t4 err",   32'(bus.o_err),   32'b010);
        check_eq("t4 grant_clr", 32'(bus.o_grant), 32'd0);
        wait_gap("t4");

        // UDP 1600 bytes without last: forced last at 1518
        bus.i_req[REQ_UDP] = 1'b1;
        step();
        check_eq("t5 grant", 32'(bus.o_grant), 32'b100);
        bad = 0;
        fwd = 0;
        for (int i = 1; i <= 1600; i++) begin
            drive_lane(REQ_UDP, data(REQ_UDP, i), 1'b1, 1'b0);
            bus.i_req[REQ_UDP] = 1'b0;
            step();
            if (i <= 1518) begin
                if (bus.o_valid !== 1'b1 || bus.o_word !== data(REQ_UDP, i) ||
                    bus.o_last !== 1'(i == 1518)) bad++;
                if (i == 1518) begin
                    check_eq("t5 err", 32'(bus.o_err), 32'b100);
                    check_eq("t5 grant_clr", 32'(bus.o_grant), 32'd0);
                end else if (bus.o_err != 3'b000) begin
                    bad++;
                end
            end else if (bus.o_valid) begin
                fwd++;
            end
        end
        drive_lane(REQ_UDP, 8'h00, 1'b0, 1'b0);
        check_eq("t5 data", 32'(bad), 32'd0);
        check_eq("t5 extra_fwd", 32'(fwd), 32'd0);
        check_eq("t5 idle busy", 32'(bus.o_busy), 32'd0);

        // Reset mid-frame at byte 20
        bus.i_req[REQ_ARP] = 1'b1;
        step();
        check_eq("t6 grant", 32'(bus.o_grant), 32'b001);
        send_frame(REQ_ARP, 20, 1'b0, "t6");
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6 rst valid", 32'(bus.o_valid), 32'd0);
        check_eq("t6 rst last",  32'(bus.o_last),  32'd0);
        check_eq("t6 rst grant", 32'(bus.o_grant), 32'd0);
        check_eq("t6 rst busy",  32'(bus.o_busy),  32'd0);
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_req[REQ_ARP] = 1'b1;
        step();
        check_eq("t6 post grant", 32'(bus.o_grant), 32'b001);
        send_frame(REQ_ARP, 5, 1'b1, "t6 post");
        wait_gap("t6 post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
